// File: rtl/ln_diff_exp_table.sv
// ln_diff_exp_table
//   Log-domain subtractor: c = ln|exp(a) - exp(b)| = max(a,b) + g(|a-b|),
//   with g(d) = ln(1 - exp(-d)) read from a ROM built at elaboration time.
//   Four-stage pipeline with valid/ready handshake on both sides; the whole
//   pipe advances together when the output slot is free or being drained.
//
//   Optional build macro: LN_DIFF_EXP_INTERP_EN
//     defined   -> linear interpolation between T[k] and T[k+1]
//     undefined -> nearest-lower table entry T[k]
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   in_valid   a/b valid
//   in_ready   block accepts a/b this cycle (combinational: !out_valid || out_ready)
//   a, b       signed fixed-point log values (FRAC fractional bits)
//   out_valid  c/flags valid
//   out_ready  downstream accepts c this cycle
//   c          ln|exp(a)-exp(b)|; min int encodes -inf
//   c_neg      exp(a) < exp(b); magnitude returned
//   c_ninf     a == b; result is -inf
module ln_diff_exp_table #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned FRAC       = 10,
    parameter int unsigned TABLE_BITS = 8,
    parameter int unsigned STEP_FRAC  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] c,
    output logic            c_neg,
    output logic            c_ninf
);

    localparam int unsigned SH    = FRAC - STEP_FRAC;
    localparam int unsigned DW    = BITS + 1;
    localparam int unsigned TBL_N = 1 << TABLE_BITS;
`ifdef LN_DIFF_EXP_INTERP_EN
    localparam int unsigned ROM_N = TBL_N + 1;
`else
    localparam int unsigned ROM_N = TBL_N;
`endif
    localparam int unsigned AW    = $clog2(ROM_N);

    localparam int                    MIN_P1_I = 1 - (1 << (BITS - 1));
    localparam logic signed [BITS-1:0] MIN_INT = {1'b1, {(BITS - 1){1'b0}}};
    localparam logic signed [BITS-1:0] MIN_P1  = BITS'(MIN_P1_I);
    localparam logic [DW-1:0]          D_MAX_FX = DW'(1) << (TABLE_BITS - STEP_FRAC + FRAC);

    // Table entry: g at the sample point, scaled to FRAC bits, rounded half away from zero.
    // Entry 0 samples half a step in, since g(0) is -inf.
    function automatic logic signed [BITS-1:0] tab_entry(input int unsigned k);
        real x;
        real s;
        int  n;
        if (k == 0)
            x = 1.0 / real'(1 << (STEP_FRAC + 1));
        else
            x = real'(k) / real'(1 << STEP_FRAC);
        s = $ln(1.0 - $exp(-x)) * real'(1 << FRAC);
        if (s < 0.0)
            n = -$rtoi(0.5 - s);
        else
            n = $rtoi(s + 0.5);
        if (n < MIN_P1_I)
            n = MIN_P1_I;
        return BITS'(n);
    endfunction

    // Correction ROM; the extra last entry (interpolation only) is the g -> 0 limit.
    logic signed [BITS-1:0] rom [ROM_N];

    for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
        if (gi < TBL_N) begin : g_ent
            localparam logic signed [BITS-1:0] ENT = tab_entry(gi);
            assign rom[gi] = ENT;
        end else begin : g_top
            assign rom[gi] = '0;
        end
    end

    // Pipeline advance: everything moves when the output slot can be refilled.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic v1, v2, v3;

    // S1 registers and difference
    logic signed [BITS-1:0] s1_a, s1_b;
    logic signed [DW-1:0]   d1;
    logic                   neg1;
    logic signed [BITS-1:0] mx1;

    assign d1   = DW'(s1_a) - DW'(s1_b);
    assign neg1 = d1[DW-1];
    assign mx1  = neg1 ? s1_b : s1_a;

    // S2 registers and table address split
    logic signed [DW-1:0]   s2_d;
    logic signed [BITS-1:0] s2_mx;
    logic                   s2_neg;
    logic [DW-1:0]          ad2;
    logic                   zero2, big2;
    logic [TABLE_BITS-1:0]  k2;

    assign ad2   = s2_neg ? DW'(-s2_d) : DW'(s2_d);
    assign zero2 = (ad2 == '0);
    assign big2  = (ad2 >= D_MAX_FX);
    assign k2    = TABLE_BITS'(ad2 >> SH);

    // S3 registers (ROM read)
    logic signed [BITS-1:0] s3_mx;
    logic                   s3_neg, s3_zero, s3_big;
    logic signed [BITS-1:0] s3_tk;
    logic signed [BITS-1:0] corr4;

`ifdef LN_DIFF_EXP_INTERP_EN
    localparam int unsigned PW = BITS + SH + 3;

    logic [SH-1:0]          r2;
    logic [SH-1:0]          s3_r;
    logic signed [BITS-1:0] s3_tk1;
    logic signed [PW-1:0]   diff4, rr4, prod4, corr_w4;

    assign r2 = ad2[SH-1:0];

    // Linear interpolation between adjacent entries; floor via arithmetic shift.
    always_comb begin
        diff4   = PW'(s3_tk1) - PW'(s3_tk);
        rr4     = PW'({1'b0, s3_r});
        prod4   = diff4 * rr4;
        corr_w4 = PW'(s3_tk) + (prod4 >>> SH);
        corr4   = BITS'(corr_w4);
    end
`else
    assign corr4 = s3_tk;
`endif

    // S4 result selection
    logic signed [DW-1:0]   sum4;
    logic [BITS-1:0]        c_nxt;
    logic                   neg_nxt, ninf_nxt;

    assign sum4 = DW'(s3_mx) + DW'(corr4);

    always_comb begin
        c_nxt    = BITS'(sum4);
        neg_nxt  = s3_neg;
        ninf_nxt = 1'b0;
        if (s3_zero) begin
            c_nxt    = MIN_INT;
            neg_nxt  = 1'b0;
            ninf_nxt = 1'b1;
        end else if (s3_big) begin
            c_nxt = s3_mx;
        end else if (sum4 < DW'(MIN_P1)) begin
            // min int is reserved for -inf; corr <= 0 so no positive overflow
            c_nxt = MIN_P1;
        end
    end

    // Valid bits and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            c         <= '0;
            c_neg     <= 1'b0;
            c_ninf    <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (v3) begin
                c      <= c_nxt;
                c_neg  <= neg_nxt;
                c_ninf <= ninf_nxt;
            end
        end
    end

    // Datapath registers; contents of bubble slots are don't-care
    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid) begin
                s1_a <= a;
                s1_b <= b;
            end
            if (v1) begin
                s2_d   <= d1;
                s2_mx  <= mx1;
                s2_neg <= neg1;
            end
            if (v2) begin
                s3_mx   <= s2_mx;
                s3_neg  <= s2_neg;
                s3_zero <= zero2;
                s3_big  <= big2;
                s3_tk   <= rom[AW'(k2)];
`ifdef LN_DIFF_EXP_INTERP_EN
                s3_tk1  <= rom[AW'(k2) + AW'(1)];
                s3_r    <= r2;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ln_diff_exp_table.sv
`timescale 1ns/1ps
module tb_ln_diff_exp_table;

`ifdef LN_DIFF_EXP_INTERP_EN
    localparam bit  INTERP = 1'b1;
    localparam real TOL    = 2.0;
`else
    localparam bit  INTERP = 1'b0;
    localparam real TOL    = 24.0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] c;
    logic        c_neg, c_ninf;

    ln_diff_exp_table dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .c_neg(c_neg), .c_ninf(c_ninf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        neg;
        logic        ninf;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    vec_t exp_q[$];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // g(d) table value from its definition, FRAC=10, step 1/16
    function automatic int tab(input int k);
        real x, v;
        int  n;
        x = (k == 0) ? (1.0 / 32.0) : (real'(k) / 16.0);
        v = $ln(1.0 - $exp(-x)) * 1024.0;
        n = (v < 0.0) ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
        if (n < -32767) n = -32767;
        return n;
    endfunction

    function automatic vec_t model(input logic [15:0] aa, input logic [15:0] bb);
        vec_t m;
        int ai, bi, d, ad, mx, k, r, tk, tk1, corr, s;
        ai = int'($signed(aa));
        bi = int'($signed(bb));
        d  = ai - bi;
        m.a = aa; m.b = bb;
        m.neg  = (d < 0);
        m.ninf = 1'b0;
        mx = (d < 0) ? bi : ai;
        ad = (d < 0) ? -d : d;
        if (ad == 0) begin
            m.c = 16'h8000; m.neg = 1'b0; m.ninf = 1'b1;
        end else if (ad >= 16 * 1024) begin
            m.c = 16'(mx);
        end else begin
            k = ad / 64;
            r = ad % 64;
            tk = tab(k);
            corr = tk;
            if (INTERP) begin
                tk1  = (k == 255) ? 0 : tab(k + 1);
                corr = tk + (((tk1 - tk) * r) >>> 6);
            end
            s = mx + corr;
            if (s < -32767) s = -32767;
            m.c = 16'(s);
        end
        return m;
    endfunction

    // Scoreboard / stability monitor, sampled mid-cycle
    logic        hold_v = 1'b0;
    logic [15:0] hold_c;
    logic        hold_n, hold_i;

    always @(negedge clk) begin
        vec_t e;
        int   ai, bi, ad, mx;
        real  ideal, err;
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) begin
                chk("stall_c", c, hold_c);
                chk("stall_flags", {c_neg, c_ninf}, {hold_n, hold_i});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_c", c, e.c);
                    chk("sb_neg", c_neg, e.neg);
                    chk("sb_ninf", c_ninf, e.ninf);
                    ai = int'($signed(e.a));
                    bi = int'($signed(e.b));
                    ad = (ai > bi) ? ai - bi : bi - ai;
                    mx = (ai > bi) ? ai : bi;
                    if (ad >= 1536) begin
                        ideal = real'(mx) + $ln(1.0 - $exp(-real'(ad) / 1024.0)) * 1024.0;
                        if (ideal > -32700.0) begin
                            err = real'(int'($signed(c))) - ideal;
                            if (err < 0.0) err = -err;
                            n_cmp++;
                            if (err > TOL) begin
                                n_bad++;
                                $display("FAIL real_err: c=%0h ideal=%f err=%f", c, ideal, err);
                            end
                        end
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_c = c; hold_n = c_neg; hold_i = c_ninf;
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Single isolated transaction; returns edges from accept to out_valid
    task automatic run_vec(input logic [15:0] va, input logic [15:0] vb, output int lat,
                           output logic [15:0] oc, output logic on, output logic oi);
        a = va; b = vb; in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        oc = c; on = c_neg; oi = c_ninf;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[9];
    int          lat, guard, out0;
    logic [15:0] oc;
    logic        on, oi, acc, saw_low, stale;

    function automatic logic [15:0] gen_b(input logic [15:0] av);
        int mode;
        mode = $urandom_range(3);
        case (mode)
            0:       return 16'($urandom);
            1:       return 16'(int'($signed(av)) + $urandom_range(600) - 300);
            2:       return 16'(int'($signed(av)) + $urandom_range(40000) - 20000);
            default: return av ^ 16'($urandom_range(7));
        endcase
    endfunction

    initial begin
        vecs[0] = '{16'h0800, 16'h0400, 16'h062A, 1'b0, 1'b0};
        vecs[1] = '{16'h0400, 16'h0800, 16'h062A, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h5000, 16'h0000, 16'h5000, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 16'h5000, 16'h5000, 1'b1, 1'b0};
        vecs[5] = '{16'h8010, 16'h800F, 16'h8001, 1'b0, 1'b0};
        vecs[6] = '{16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_flags", {c_neg, c_ninf}, 0);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();

        // Directed vectors with latency check
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i].a, vecs[i].b, lat, oc, on, oi);
            chk($sformatf("vec%0d_lat", i), lat, 4);
            chk($sformatf("vec%0d_c", i), oc, vecs[i].c);
            chk($sformatf("vec%0d_neg", i), on, vecs[i].neg);
            chk($sformatf("vec%0d_ninf", i), oi, vecs[i].ninf);
        end

        // Back-to-back stream with a 3-cycle output stall
        out0 = n_out;
        saw_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = 16'($urandom); b = gen_b(a); in_valid = 1'b1;
                    acc = 1'b0; guard = 0;
                    while (!acc && guard < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        if (!in_ready) saw_low = 1'b1;
                        tick();
                        guard++;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
            tick();
            guard++;
        end
        chk("stream_count", n_out - out0, 6);
        chk("stream_in_ready_low", saw_low, 1);

        // Reset with results in flight
        for (int i = 0; i < 4; i++) begin
            a = 16'h0800 + 16'(i * 16); b = 16'h0400; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", stale, 0);
        run_vec(16'h0800, 16'h0400, lat, oc, on, oi);
        chk("postrst_lat", lat, 4);
        chk("postrst_c", oc, 16'h062A);

        // Random sweep with random gaps and backpressure
        guard = 0;
        for (int i = 0; i < 300 && guard < 5000; ) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                a = ($urandom_range(3) == 0) ? (16'h8000 + 16'($urandom_range(2000))) : 16'($urandom);
                b = gen_b(a);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) i++;
            tick();
            if (acc) in_valid = 1'b0;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
            tick();
            guard++;
        end
        chk("sweep_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
